// File: rtl/battle_pkg.sv
// Shared state encoding and menu opcodes for the battle turn sequencer.
package battle_pkg;

    typedef enum logic [3:0] {
        S_MENU       = 4'd0,
        S_LOAD_PM    = 4'd1,
        S_P_ATK      = 4'd2,
        S_AI_ATK     = 4'd3,
        S_HEAL       = 4'd4,
        S_CATCH      = 4'd5,
        S_CATCH_FAIL = 4'd6,
        S_CAUGHT     = 4'd7,
        S_FLED       = 4'd8,
        S_VICTORY    = 4'd9,
        S_LOSS       = 4'd10
    } state_t;

    localparam logic [1:0] MV_BATTLE = 2'b00;
    localparam logic [1:0] MV_HEAL   = 2'b01;
    localparam logic [1:0] MV_CATCH  = 2'b10;
    localparam logic [1:0] MV_RUN    = 2'b11;

endpackage

// File: rtl/battle_turn_ctrl_if.sv
// Menu/datapath-facing signal bundle of the battle turn sequencer.
interface battle_turn_ctrl_if #(
    parameter int TURN_W      = 8,
    parameter int HEAL_LIMIT  = 3,
    parameter int CATCH_LIMIT = 5
);
    localparam int HEAL_W  = $clog2(HEAL_LIMIT + 1);
    localparam int CATCH_W = $clog2(CATCH_LIMIT + 1);

    logic               go;
    logic [1:0]         move_op;
    logic               dp_done;
    logic               ai_dead;
    logic               p_dead;
    logic               catch_success;

    logic               active_trainer;
    logic               target;
    logic               apply_p_damage;
    logic               apply_ai_damage;
    logic               p_heal;
    logic               catch;
    logic               catch_fail;
    logic               caught;
    logic               victory;
    logic               loss;
    logic               fled;
    logic               busy;
    logic               op_reject;
    logic [3:0]         state_code;
    logic [TURN_W-1:0]  turn_count;
    logic [HEAL_W-1:0]  heals_left;
    logic [CATCH_W-1:0] catches_left;

    modport master (
        output go, move_op, dp_done, ai_dead, p_dead, catch_success,
        input  active_trainer, target, apply_p_damage, apply_ai_damage, p_heal,
               catch, catch_fail, caught, victory, loss, fled, busy, op_reject,
               state_code, turn_count, heals_left, catches_left
    );

    modport slave (
        input  go, move_op, dp_done, ai_dead, p_dead, catch_success,
        output active_trainer, target, apply_p_damage, apply_ai_damage, p_heal,
               catch, catch_fail, caught, victory, loss, fled, busy, op_reject,
               state_code, turn_count, heals_left, catches_left
    );

endinterface

// File: rtl/battle_sat_counter.sv
// Budget counter: loads LIMIT on reset, decrements toward zero and sticks there.
module battle_sat_counter #(
    parameter  int LIMIT = 3,
    localparam int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= W'(LIMIT);
        else if (i_dec && (r_count != '0))
            r_count <= r_count - 1'b1;
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/battle_turn_ctrl.sv
// Battle turn sequencer: menu decode, action handshakes with the HP datapath, budgets and turn count.
module battle_turn_ctrl
    import battle_pkg::*;
#(
    parameter int HEAL_LIMIT  = 3,
    parameter int CATCH_LIMIT = 5,
    parameter int TURN_W      = 8,
    parameter int AI_FIRST    = 0
) (
    input  logic               clk,
    input  logic               reset,
    battle_turn_ctrl_if.slave  bus
);

    localparam int HEAL_W  = $clog2(HEAL_LIMIT + 1);
    localparam int CATCH_W = $clog2(CATCH_LIMIT + 1);
    localparam bit AI_LEADS = (AI_FIRST != 0);

    state_t             r_state;
    state_t             w_next;
    logic               r_p_pending;
    logic               r_op_reject;
    logic [TURN_W-1:0]  r_turn_count;
    logic               w_reject;
    logic               w_heal_dec;
    logic               w_catch_dec;
    logic               w_heal_zero;
    logic               w_catch_zero;
    logic [HEAL_W-1:0]  w_heals_left;
    logic [CATCH_W-1:0] w_catches_left;

    battle_sat_counter #(.LIMIT(HEAL_LIMIT)) u_heal_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_dec   (w_heal_dec),
        .o_count (w_heals_left),
        .o_zero  (w_heal_zero)
    );

    battle_sat_counter #(.LIMIT(CATCH_LIMIT)) u_catch_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_dec   (w_catch_dec),
        .o_count (w_catches_left),
        .o_zero  (w_catch_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_MENU;
        else
            r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next   = r_state;
        w_reject = 1'b0;
        case (r_state)
            S_MENU: if (bus.go) begin
                case (bus.move_op)
                    MV_BATTLE: w_next = S_LOAD_PM;
                    MV_HEAL:   if (!w_heal_zero)  w_next = S_HEAL;  else w_reject = 1'b1;
                    MV_CATCH:  if (!w_catch_zero) w_next = S_CATCH; else w_reject = 1'b1;
                    default:   w_next = S_FLED;
                endcase
            end
            S_LOAD_PM:    w_next = AI_LEADS ? S_AI_ATK : S_P_ATK;
            S_P_ATK:      if (bus.dp_done) w_next = bus.ai_dead ? S_VICTORY
                                                  : (AI_LEADS ? S_MENU : S_AI_ATK);
            S_AI_ATK:     if (bus.dp_done) w_next = bus.p_dead ? S_LOSS
                                                  : (r_p_pending ? S_P_ATK : S_MENU);
            S_HEAL:       if (bus.dp_done) w_next = S_AI_ATK;
            S_CATCH:      if (bus.dp_done) w_next = bus.catch_success ? S_CAUGHT : S_CATCH_FAIL;
            S_CATCH_FAIL: if (bus.dp_done) w_next = S_AI_ATK;
            S_CAUGHT, S_FLED, S_VICTORY, S_LOSS: w_next = r_state;
            default:      w_next = S_MENU;
        endcase
    end

    assign w_heal_dec  = (r_state == S_MENU) && (w_next == S_HEAL);
    assign w_catch_dec = (r_state == S_MENU) && (w_next == S_CATCH);

    // A player strike is owed after the AI opens the turn; cleared once it is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_p_pending <= 1'b0;
        else if (r_state == S_LOAD_PM)
            r_p_pending <= AI_LEADS;
        else if (r_state == S_P_ATK)
            r_p_pending <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_turn_count <= '0;
            r_op_reject  <= 1'b0;
        end else begin
            r_op_reject <= w_reject;
            if ((w_next == S_MENU) && (r_state != S_MENU) && (r_turn_count != '1))
                r_turn_count <= r_turn_count + 1'b1;
        end
    end

    always_comb begin
        bus.active_trainer  = 1'b0;
        bus.target          = 1'b0;
        bus.apply_p_damage  = 1'b0;
        bus.apply_ai_damage = 1'b0;
        bus.p_heal          = 1'b0;
        bus.catch           = 1'b0;
        bus.catch_fail      = 1'b0;
        bus.caught          = 1'b0;
        bus.victory         = 1'b0;
        bus.loss            = 1'b0;
        bus.fled            = 1'b0;
        bus.busy            = 1'b0;
        case (r_state)
            S_LOAD_PM:    bus.busy = 1'b1;
            S_P_ATK: begin
                bus.busy            = 1'b1;
                bus.target          = 1'b1;
                bus.apply_ai_damage = 1'b1;
            end
            S_AI_ATK: begin
                bus.busy           = 1'b1;
                bus.active_trainer = 1'b1;
                bus.apply_p_damage = 1'b1;
            end
            S_HEAL:       begin bus.busy = 1'b1; bus.p_heal     = 1'b1; end
            S_CATCH:      begin bus.busy = 1'b1; bus.catch      = 1'b1; end
            S_CATCH_FAIL: begin bus.busy = 1'b1; bus.catch_fail = 1'b1; end
            S_CAUGHT:     bus.caught  = 1'b1;
            S_FLED:       bus.fled    = 1'b1;
            S_VICTORY:    bus.victory = 1'b1;
            S_LOSS:       bus.loss    = 1'b1;
            default:      ;
        endcase
    end

    assign bus.state_code   = r_state;
    assign bus.op_reject    = r_op_reject;
    assign bus.turn_count   = r_turn_count;
    assign bus.heals_left   = w_heals_left;
    assign bus.catches_left = w_catches_left;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Directed bench for battle_turn_ctrl: player-first and AI-first instances, hand-computed expectations.
module tb_battle_turn_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    battle_turn_ctrl_if #(.TURN_W(8), .HEAL_LIMIT(3), .CATCH_LIMIT(5)) if0 ();
    battle_turn_ctrl_if #(.TURN_W(8), .HEAL_LIMIT(3), .CATCH_LIMIT(5)) if1 ();

    battle_turn_ctrl #(.HEAL_LIMIT(3), .CATCH_LIMIT(5), .TURN_W(8), .AI_FIRST(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    battle_turn_ctrl #(.HEAL_LIMIT(3), .CATCH_LIMIT(5), .TURN_W(8), .AI_FIRST(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        if0.go = 1'b0; if0.move_op = 2'b00; if0.dp_done = 1'b0;
        if0.ai_dead = 1'b0; if0.p_dead = 1'b0; if0.catch_success = 1'b0;
        if1.go = 1'b0; if1.move_op = 2'b00; if1.dp_done = 1'b0;
        if1.ai_dead = 1'b0; if1.p_dead = 1'b0; if1.catch_success = 1'b0;
        #2;
        check("rst_state",   if0.state_code, 0);
        check("rst_turn",    if0.turn_count, 0);
        check("rst_heals",   if0.heals_left, 3);
        check("rst_catches", if0.catches_left, 5);
        check("rst_busy",    if0.busy, 0);
        check("rst_reject",  if0.op_reject, 0);
        #8 reset = 1'b0;

        // Player-first battle turn
        step();
        check("t1_idle", if0.state_code, 0);
        if0.go = 1'b1; if0.move_op = 2'b00;
        step();
        check("t1_load", if0.state_code, 1);
        if0.go = 1'b0;
        step();
        check("t1_patk",     if0.state_code, 2);
        check("t1_aidmg",    if0.apply_ai_damage, 1);
        check("t1_target",   if0.target, 1);
        check("t1_trainer0", if0.active_trainer, 0);
        check("t1_busy",     if0.busy, 1);
        step();
        check("t1_patk_hold", if0.state_code, 2);
        if0.dp_done = 1'b1;
        step();
        check("t1_aiatk",    if0.state_code, 3);
        check("t1_pdmg",     if0.apply_p_damage, 1);
        check("t1_trainer1", if0.active_trainer, 1);
        step();
        if0.dp_done = 1'b0;
        check("t1_menu", if0.state_code, 0);
        check("t1_turn", if0.turn_count, 1);

        // AI-first battle turn
        if1.go = 1'b1; if1.move_op = 2'b00;
        step();
        if1.go = 1'b0;
        check("t2_load", if1.state_code, 1);
        step();
        check("t2_aiatk", if1.state_code, 3);
        check("t2_pdmg",  if1.apply_p_damage, 1);
        check("t2_aidmg0", if1.apply_ai_damage, 0);
        if1.dp_done = 1'b1;
        step();
        check("t2_patk",  if1.state_code, 2);
        check("t2_aidmg", if1.apply_ai_damage, 1);
        step();
        if1.dp_done = 1'b0;
        check("t2_menu", if1.state_code, 0);
        check("t2_turn", if1.turn_count, 1);

        // Heal budget: three granted, fourth rejected
        for (int i = 0; i < 3; i++) begin
            if0.go = 1'b1; if0.move_op = 2'b01;
            step();
            if0.go = 1'b0;
            check("t3_heal",  if0.state_code, 4);
            check("t3_pheal", if0.p_heal, 1);
            check("t3_left",  if0.heals_left, 2 - i);
            if0.dp_done = 1'b1;
            step();
            check("t3_aiatk", if0.state_code, 3);
            step();
            if0.dp_done = 1'b0;
            check("t3_menu", if0.state_code, 0);
        end
        check("t3_turn", if0.turn_count, 4);
        if0.go = 1'b1; if0.move_op = 2'b01;
        step();
        if0.go = 1'b0;
        check("t3_rej_state", if0.state_code, 0);
        check("t3_rej_pulse", if0.op_reject, 1);
        check("t3_rej_heals", if0.heals_left, 0);
        step();
        check("t3_rej_drop", if0.op_reject, 0);
        check("t3_rej_turn", if0.turn_count, 4);

        // Catch: fail, AI retaliates, then success
        if0.go = 1'b1; if0.move_op = 2'b10;
        step();
        if0.go = 1'b0;
        check("t4_catch",   if0.state_code, 5);
        check("t4_catch_o", if0.catch, 1);
        check("t4_left",    if0.catches_left, 4);
        if0.dp_done = 1'b1; if0.catch_success = 1'b0;
        step();
        check("t4_cfail",   if0.state_code, 6);
        check("t4_cfail_o", if0.catch_fail, 1);
        step();
        check("t4_aiatk", if0.state_code, 3);
        step();
        if0.dp_done = 1'b0;
        check("t4_menu", if0.state_code, 0);
        check("t4_turn", if0.turn_count, 5);
        if0.go = 1'b1; if0.move_op = 2'b10;
        step();
        if0.go = 1'b0;
        check("t4_catch2", if0.state_code, 5);
        check("t4_left2",  if0.catches_left, 3);
        if0.dp_done = 1'b1; if0.catch_success = 1'b1;
        step();
        if0.dp_done = 1'b0; if0.catch_success = 1'b0;
        check("t4_caught",   if0.state_code, 7);
        check("t4_caught_o", if0.caught, 1);
        if0.go = 1'b1; if0.move_op = 2'b00;
        step(); step();
        if0.go = 1'b0;
        check("t4_hold",   if0.state_code, 7);
        check("t4_hold_o", if0.caught, 1);
        check("t4_busy",   if0.busy, 0);

        // Both death flags on the player strike: victory wins
        #3 reset = 1'b1;
        #1 check("t5_rst_state", if0.state_code, 0);
        #1 reset = 1'b0;
        if0.go = 1'b1; if0.move_op = 2'b00;
        step();
        if0.go = 1'b0;
        step();
        check("t5_patk", if0.state_code, 2);
        if0.dp_done = 1'b1; if0.ai_dead = 1'b1; if0.p_dead = 1'b1;
        step();
        if0.dp_done = 1'b0; if0.ai_dead = 1'b0; if0.p_dead = 1'b0;
        check("t5_victory", if0.state_code, 9);
        check("t5_vic_o",   if0.victory, 1);
        check("t5_loss_o",  if0.loss, 0);
        step();
        check("t5_vic_hold", if0.state_code, 9);

        // Reset in the middle of a heal drops the strobe at once
        #3 reset = 1'b1;
        #1 reset = 1'b0;
        step();
        if0.go = 1'b1; if0.move_op = 2'b01;
        step();
        if0.go = 1'b0;
        check("t6_heal",  if0.state_code, 4);
        check("t6_heals", if0.heals_left, 2);
        #2 reset = 1'b1;
        #1;
        check("t6_abort_state", if0.state_code, 0);
        check("t6_abort_pheal", if0.p_heal, 0);
        check("t6_abort_heals", if0.heals_left, 3);
        #2 reset = 1'b0;

        // Run option
        step();
        if0.go = 1'b1; if0.move_op = 2'b11;
        step();
        if0.go = 1'b0;
        check("t7_fled",   if0.state_code, 8);
        check("t7_fled_o", if0.fled, 1);
        check("t7_turn",   if0.turn_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
